// File: rtl/capsense_pkg.sv
`default_nettype none
// ============================================================================
// Module      : capsense_pkg
// Description : Shared types for the capacitive-sense sampler: the sampler
//               FSM state enum, the default counter width, the count type
//               and a helper that locates a channel inside the packed
//               sense_count bus.
// Revision    : 1.0 - initial release
// ============================================================================
package capsense_pkg;

  localparam int unsigned CountWidthDef = 16;

  typedef logic [CountWidthDef-1:0] count_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DISCHARGE = 3'd1,
    ST_CHARGE    = 3'd2,
    ST_DONE      = 3'd3,
    ST_GAP       = 3'd4
  } state_e;

  // LSB position of channel 'ch' inside a packed bus of 'width'-bit fields.
  function automatic int unsigned count_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/capsense_sampler_if.sv
`default_nettype none
// ============================================================================
// Module      : capsense_sampler_if
// Description : Register-side and pin-side signal bundle of the sampler.
//   enable       : level, keep sampling while high
//   threshold    : touch threshold (strict greater-than)
//   sense_in     : raw asynchronous sensor pins
//   charge_out   : drive to the RC charge network
//   sense_count  : published counts, channel i at [i*CountWidth +: CountWidth]
//   touched      : per-channel touch flags
//   fault        : per-channel discharge/rise timeout flags
//   sample_valid : one-cycle pulse when the published outputs update
//   busy         : high whenever the sampler is not idle
// Modports    : master (register file / pins), slave (sampler)
// Revision    : 1.0 - initial release
// ============================================================================
interface capsense_sampler_if #(
  parameter int unsigned NumSense   = 4,
  parameter int unsigned CountWidth = 16
);
  logic                           enable;
  logic [CountWidth-1:0]          threshold;
  logic [NumSense-1:0]            sense_in;
  logic                           charge_out;
  logic [NumSense*CountWidth-1:0] sense_count;
  logic [NumSense-1:0]            touched;
  logic [NumSense-1:0]            fault;
  logic                           sample_valid;
  logic                           busy;

  modport master (
    output enable, threshold, sense_in,
    input  charge_out, sense_count, touched, fault, sample_valid, busy
  );

  modport slave (
    input  enable, threshold, sense_in,
    output charge_out, sense_count, touched, fault, sample_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/capsense_channel.sv
`default_nettype none
// ============================================================================
// Module      : capsense_channel
// Description : One sensor channel: input synchronizer, rise-time latch and
//               pending-fault bit. Driven by the sampler state and the shared
//               phase counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   sense_i      : raw asynchronous sensor pin
//   state_i      : current sampler state
//   cnt_i        : shared phase counter
//   synced_o     : synchronized sensor level
//   hit_o        : channel latches on this cycle
//   latched_o    : channel has latched for the current sample
//   count_o      : latched rise count
//   pend_fault_o : fault pending publication
// Revision    : 1.0 - initial release
// ============================================================================
module capsense_channel
  import capsense_pkg::*;
#(
  parameter int unsigned CountWidth    = CountWidthDef,
  parameter int unsigned TimeoutCycles = 50000,
  parameter int unsigned SyncStages    = 2
) (
  input  wire logic                  clk,
  input  wire logic                  reset_n,
  input  wire logic                  sense_i,
  input  wire state_e                state_i,
  input  wire logic [CountWidth-1:0] cnt_i,
  output logic                       synced_o,
  output logic                       hit_o,
  output logic                       latched_o,
  output logic [CountWidth-1:0]      count_o,
  output logic                       pend_fault_o
);

  localparam logic [CountWidth-1:0] TimeoutLast = CountWidth'(TimeoutCycles - 1);

  logic [SyncStages-1:0] sync_q;
  logic                  latched_q;
  logic                  pend_q;
  logic [CountWidth-1:0] count_q;
  logic                  at_timeout;

  assign at_timeout = (cnt_i == TimeoutLast);
  assign synced_o   = sync_q[SyncStages-1];

  // A channel that never rose is forced to latch on the last CHARGE cycle so
  // that it carries the timeout value.
  assign hit_o        = (state_i == ST_CHARGE) && !latched_q && (synced_o || at_timeout);
  assign latched_o    = latched_q;
  assign count_o      = count_q;
  assign pend_fault_o = pend_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      latched_q <= 1'b0;
      pend_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], sense_i};
      case (state_i)
        ST_DISCHARGE: begin
          latched_q <= 1'b0;
          if (at_timeout && synced_o) pend_q <= 1'b1;
        end
        ST_CHARGE: begin
          if (hit_o) begin
            latched_q <= 1'b1;
            count_q   <= cnt_i;
            if (!synced_o) pend_q <= 1'b1;
          end
        end
        // Pending bit is published by the top in DONE, then cleared here.
        ST_DONE: pend_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/capsense_sampler.sv
`default_nettype none
// ============================================================================
// Module      : capsense_sampler
// Description : Capacitive-sense sampler. Discharges the RC network, drives
//               charge_out and times the rise on each sensor pin, then
//               publishes counts, touch flags and fault flags.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : capsense_sampler_if.slave (enable, threshold, sense_in,
//             charge_out, sense_count, touched, fault, sample_valid, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module capsense_sampler
  import capsense_pkg::*;
#(
  parameter int unsigned NumSense      = 4,
  parameter int unsigned CountWidth    = CountWidthDef,
  parameter int unsigned TimeoutCycles = 50000,
  parameter int unsigned SettleCycles  = 500,
  parameter int unsigned GapCycles     = 1000,
  parameter int unsigned SyncStages    = 2
) (
  input wire logic          clk,
  input wire logic          reset_n,
  capsense_sampler_if.slave bus
);

  localparam logic [CountWidth-1:0] TimeoutLast = CountWidth'(TimeoutCycles - 1);
  localparam logic [CountWidth-1:0] SettleLast  = CountWidth'(SettleCycles - 1);
  localparam logic [CountWidth-1:0] GapLast     = CountWidth'(GapCycles - 1);

  state_e                         state_q;
  logic [CountWidth-1:0]          cnt_q;
  logic                           charge_out_q;
  logic                           busy_q;
  logic [NumSense*CountWidth-1:0] sense_count_q;
  logic [NumSense-1:0]            touched_q;
  logic [NumSense-1:0]            fault_q;
  logic                           sample_valid_q;

  logic [NumSense-1:0]            synced;
  logic [NumSense-1:0]            hit;
  logic [NumSense-1:0]            latched;
  logic [NumSense-1:0]            pend;
  logic [NumSense*CountWidth-1:0] counts;
  logic [NumSense-1:0]            touched_d;
  logic [CountWidth-1:0]          cnt_inc;

  for (genvar g = 0; g < NumSense; g++) begin : g_chan
    capsense_channel #(
      .CountWidth    (CountWidth),
      .TimeoutCycles (TimeoutCycles),
      .SyncStages    (SyncStages)
    ) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .sense_i      (bus.sense_in[g]),
      .state_i      (state_q),
      .cnt_i        (cnt_q),
      .synced_o     (synced[g]),
      .hit_o        (hit[g]),
      .latched_o    (latched[g]),
      .count_o      (counts[g*CountWidth +: CountWidth]),
      .pend_fault_o (pend[g])
    );
  end

  // Phase counter saturates instead of wrapping.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    touched_d = '0;
    for (int unsigned i = 0; i < NumSense; i++) begin
      touched_d[i] = counts[count_lsb(i, CountWidth) +: CountWidth] > bus.threshold;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      charge_out_q   <= 1'b0;
      busy_q         <= 1'b0;
      sense_count_q  <= '0;
      touched_q      <= '0;
      fault_q        <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (bus.enable) begin
            state_q <= ST_DISCHARGE;
            busy_q  <= 1'b1;
          end
        end
        ST_DISCHARGE: begin
          if ((cnt_q >= SettleLast && synced == '0) || cnt_q == TimeoutLast) begin
            state_q      <= ST_CHARGE;
            cnt_q        <= '0;
            charge_out_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        ST_CHARGE: begin
          // Channels latching this very cycle count as done, so DONE follows
          // immediately after the last latch.
          if ((&(latched | hit)) || cnt_q == TimeoutLast) begin
            state_q      <= ST_DONE;
            cnt_q        <= '0;
            charge_out_q <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        ST_DONE: begin
          // All published outputs load together on this edge.
          state_q        <= ST_GAP;
          cnt_q          <= '0;
          sense_count_q  <= counts;
          touched_q      <= touched_d;
          fault_q        <= pend;
          sample_valid_q <= 1'b1;
        end
        ST_GAP: begin
          if (cnt_q == GapLast) begin
            cnt_q <= '0;
            if (bus.enable) begin
              state_q <= ST_DISCHARGE;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          cnt_q        <= '0;
          charge_out_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.charge_out   = charge_out_q;
  assign bus.busy         = busy_q;
  assign bus.sense_count  = sense_count_q;
  assign bus.touched      = touched_q;
  assign bus.fault        = fault_q;
  assign bus.sample_valid = sample_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_capsense_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_capsense_sampler
// Description : Self-checking bench for capsense_sampler. Expected counts,
//               flags and phase lengths come from the sampling rules:
//               count = rise delay + sync latency, timeout -> TO-1 plus fault,
//               touched = count > threshold. Timeout is shortened so the two
//               timeout scenarios stay short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_capsense_sampler;
  import capsense_pkg::*;

  localparam int NS     = 4;
  localparam int CW     = 16;
  localparam int TO     = 3000;
  localparam int SETTLE = 500;
  localparam int GAP    = 1000;
  localparam int SYNC   = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  capsense_sampler_if #(.NumSense(NS), .CountWidth(CW)) bus ();

  capsense_sampler #(
    .NumSense      (NS),
    .CountWidth    (CW),
    .TimeoutCycles (TO),
    .SettleCycles  (SETTLE),
    .GapCycles     (GAP),
    .SyncStages    (SYNC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned last_sv_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what a channel should report for a pin rising k cycles after
  // charge_out (k<0: never rises), or held high through discharge.
  function automatic count_t model_count(input int k, input bit pre);
    if (pre) return '0;
    if (k < 0 || k + SYNC > TO - 1) return count_t'(TO - 1);
    return count_t'(k + SYNC);
  endfunction

  task automatic do_sample(input string tag, input int k[NS], input logic [NS-1:0] pre,
                           input logic [CW-1:0] thr, input bit chk_disch,
                           input bit chk_period, input int drop_en_c);
    count_t            exp_cnt[NS];
    logic [NS-1:0]     exp_t, exp_f;
    logic [NS*CW-1:0]  exp_bus;
    int                exp_dur;
    int                fall_c, sv_c;
    int unsigned       rise_cyc;
    bit                seen;
    exp_dur = 0;
    exp_bus = '0;
    for (int i = 0; i < NS; i++) begin
      exp_cnt[i] = model_count(k[i], pre[i]);
      exp_f[i]   = pre[i] || k[i] < 0 || k[i] + SYNC > TO - 1;
      exp_t[i]   = exp_cnt[i] > thr;
      exp_bus[i*CW +: CW] = exp_cnt[i];
      if (int'(exp_cnt[i]) + 1 > exp_dur) exp_dur = int'(exp_cnt[i]) + 1;
    end
    bus.threshold = thr;
    bus.sense_in  = pre;
    seen = 0;
    for (int n = 0; n < 2*TO + GAP + 100; n++) begin
      @(posedge clk); #1;
      if (bus.charge_out) begin seen = 1; break; end
    end
    check({tag, ":charge_rise"}, bus.charge_out, 1'b1);
    if (!seen) return;
    rise_cyc = cyc;
    if (chk_disch)
      check({tag, ":discharge_len"}, rise_cyc - last_sv_cyc - GAP, (pre != 0) ? TO : SETTLE);
    for (int i = 0; i < NS; i++) if (!pre[i] && k[i] == 0) bus.sense_in[i] = 1'b1;
    fall_c = -1;
    sv_c   = -1;
    for (int c = 1; c <= TO + 10; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NS; i++) if (!pre[i] && k[i] == c) bus.sense_in[i] = 1'b1;
      if (c == drop_en_c) bus.enable = 1'b0;
      if (fall_c < 0 && !bus.charge_out) fall_c = c;
      if (bus.sample_valid) begin sv_c = c; break; end
    end
    check({tag, ":charge_len"}, fall_c, exp_dur);
    check({tag, ":sv_delay"}, sv_c, exp_dur + 1);
    check({tag, ":sense_count"}, bus.sense_count, exp_bus);
    check({tag, ":touched"}, bus.touched, exp_t);
    check({tag, ":fault"}, bus.fault, exp_f);
    if (chk_period)
      check({tag, ":period"}, cyc - last_sv_cyc, SETTLE + (exp_dur - 1) + 1 + 1 + GAP);
    last_sv_cyc  = cyc;
    bus.sense_in = '0;
    @(posedge clk); #1;
    check({tag, ":sv_one_cycle"}, bus.sample_valid, 1'b0);
    check({tag, ":hold_count"}, bus.sense_count, exp_bus);
  endtask

  initial begin
    int          kk[NS];
    logic [CW-1:0] thr;
    bit          bad_co, bad_sv, bad_busy;
    bus.enable    = 1'b0;
    bus.threshold = '0;
    bus.sense_in  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst:charge_out", bus.charge_out, 1'b0);
    check("rst:busy", bus.busy, 1'b0);
    check("rst:sense_count", bus.sense_count, '0);
    check("rst:touched", bus.touched, '0);
    check("rst:fault", bus.fault, '0);
    check("rst:sample_valid", bus.sample_valid, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle:busy", bus.busy, 1'b0);

    // Staggered rises, threshold 250
    bus.enable = 1'b1;
    do_sample("staggered", '{100, 200, 300, 400}, 4'b0000, 16'd250, 0, 0, -1);

    // Channel 2 never rises, then the next sample still runs
    do_sample("ch2_dead", '{50, 50, -1, 50}, 4'b0000, 16'd250, 1, 0, -1);
    for (int i = 0; i < NS; i++) kk[i] = int'($urandom_range(0, 600));
    thr = 16'($urandom_range(0, 700));
    do_sample("after_dead", kk, 4'b0000, thr, 1, 0, -1);

    // Channel 0 stuck high through discharge
    for (int i = 0; i < NS; i++) kk[i] = int'($urandom_range(0, 600));
    do_sample("ch0_stuck", kk, 4'b0001, 16'd100, 1, 0, -1);

    // Random samples
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < NS; i++) kk[i] = int'($urandom_range(0, 600));
      thr = 16'($urandom_range(0, 700));
      do_sample("random", kk, 4'b0000, thr, 1, 0, -1);
    end

    // All channels on the same cycle, full sample period
    do_sample("same_cycle", '{10, 10, 10, 10}, 4'b0000, 16'd11, 1, 1, -1);

    // enable dropped during CHARGE
    for (int i = 0; i < NS; i++) kk[i] = int'($urandom_range(20, 600));
    do_sample("drop_en", kk, 4'b0000, 16'd300, 1, 0, 5);
    for (int n = 0; n < GAP + 50; n++) begin
      @(posedge clk); #1;
      if (!bus.busy) break;
    end
    check("drop_en:busy_fall", cyc - last_sv_cyc, GAP);
    bad_co = 0; bad_sv = 0; bad_busy = 0;
    repeat (100) begin
      @(posedge clk); #1;
      bad_co   |= bus.charge_out;
      bad_sv   |= bus.sample_valid;
      bad_busy |= bus.busy;
    end
    check("drop_en:charge_quiet", bad_co, 1'b0);
    check("drop_en:no_sv", bad_sv, 1'b0);
    check("drop_en:stay_idle", bad_busy, 1'b0);

    // Asynchronous reset mid-CHARGE
    bus.enable = 1'b1;
    for (int n = 0; n < SETTLE + 50; n++) begin
      @(posedge clk); #1;
      if (bus.charge_out) break;
    end
    check("rst_mid:charge_rise", bus.charge_out, 1'b1);
    repeat (20) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("rst_mid:charge_out", bus.charge_out, 1'b0);
    check("rst_mid:busy", bus.busy, 1'b0);
    check("rst_mid:sense_count", bus.sense_count, '0);
    check("rst_mid:touched", bus.touched, '0);
    check("rst_mid:fault", bus.fault, '0);
    bus.sense_in = '0;
    bad_sv = 0;
    repeat (5) begin
      @(posedge clk); #1;
      bad_sv |= bus.sample_valid;
    end
    check("rst_mid:no_sv", bad_sv, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < NS; i++) kk[i] = int'($urandom_range(0, 600));
    thr = 16'($urandom_range(0, 700));
    do_sample("rst_restart", kk, 4'b0000, thr, 0, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
